// File: rtl/cfg_regbank_if.sv
`default_nettype none
// ===========================================================================
// cfg_regbank_if -- command, sync and readback bus of cfg_regbank (rev 1.0)
// ===========================================================================
interface cfg_regbank_if #(
  parameter int NCH    = 16,
  parameter int FW     = 8,
  parameter int NFIELD = 7
);
  logic [31:0]              data;
  logic                     valid;
  logic                     sync;
  logic [NFIELD*NCH*FW-1:0] cfg;
  logic                     pending;
  logic                     upd;
  logic                     rd_valid;
  logic [31:0]              rd_data;
  logic                     err;
  logic [7:0]               err_cnt;

  modport master (
    output data, valid, sync,
    input  cfg, pending, upd, rd_valid, rd_data, err, err_cnt
  );

  modport slave (
    input  data, valid, sync,
    output cfg, pending, upd, rd_valid, rd_data, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cfg_regbank.sv
`default_nettype none
// ===========================================================================
// cfg_regbank -- per-channel config register file; CFG_SHADOW_EN adds a
// shadow bank committed on sync. Revision 1.0
// ===========================================================================
module cfg_regbank #(
  parameter int                   NCH    = 16,
  parameter int                   FW     = 8,
  parameter int                   NFIELD = 7,
  parameter logic [NFIELD*FW-1:0] DEF    = '0
) (
  input  logic         clk20,
  input  logic         res,
  cfg_regbank_if.slave bus
);
  localparam int         c_nreg_i      = NFIELD * NCH;
  localparam logic [7:0] c_nreg        = 8'(NFIELD * NCH);
  localparam logic [7:0] c_addr_last   = 8'hFD;
  localparam logic [7:0] c_addr_rd     = 8'hFE;
  localparam logic [7:0] c_addr_commit = 8'hFF;

  logic [7:0]             addr_w;
  logic [7:0]             tgt_w;
  logic [7:0]             tgt_idx_w;
  logic [FW-1:0]          payload_w;
  logic [FW-1:0]          rd_val_w;
  logic                   wr_w;
  logic                   commit_w;
  logic                   rd_w;
  logic                   bad_w;
  logic                   tgt_ok_w;
  logic                   err_w;
  logic                   pending_w;
  logic                   upd_d;
  logic [c_nreg_i*FW-1:0] act_flat_w;
  logic                   unused_w;

  logic                   upd_q;
  logic                   rd_valid_q;
  logic [31:0]            rd_data_q;
  logic                   err_q;
  logic [7:0]             err_cnt_q;

  assign addr_w    = bus.data[31:24];
  assign tgt_w     = bus.data[7:0];
  assign payload_w = bus.data[FW-1:0];
  assign wr_w      = bus.valid && (addr_w < c_nreg);
  assign commit_w  = bus.valid && (addr_w == c_addr_commit);
  assign rd_w      = bus.valid && (addr_w == c_addr_rd);
  assign bad_w     = bus.valid && (addr_w >= c_nreg) && (addr_w <= c_addr_last);
  assign tgt_ok_w  = tgt_w < c_nreg;
  assign tgt_idx_w = tgt_ok_w ? tgt_w : 8'd0;
  assign rd_val_w  = tgt_ok_w ? act_flat_w[int'(tgt_idx_w)*FW +: FW] : '0;
  assign err_w     = bad_w || (rd_w && !tgt_ok_w);
  assign unused_w  = ^{bus.data, bus.sync, commit_w};

`ifdef CFG_SHADOW_EN
  logic pending_q;
  logic copy_w;

  // Copy needs a sync strobe plus either an armed or a same-cycle commit.
  assign copy_w    = bus.sync && (pending_q || commit_w);
  assign pending_w = pending_q;
  assign upd_d     = copy_w;

  always_ff @(posedge clk20) begin
    if (res) begin
      pending_q <= 1'b0;
    end else if (copy_w) begin
      pending_q <= 1'b0;
    end else if (commit_w) begin
      pending_q <= 1'b1;
    end
  end
`else
  assign pending_w = 1'b0;
  assign upd_d     = wr_w;
`endif

  // With NCH a power of two, field*NCH + channel is the address itself.
  for (genvar i = 0; i < c_nreg_i; i++) begin : g_reg
    localparam logic [FW-1:0] c_def = DEF[(i/NCH)*FW +: FW];
    logic          hit_w;
    logic [FW-1:0] act_q;

    assign hit_w = wr_w && (addr_w == 8'(i));

`ifdef CFG_SHADOW_EN
    logic [FW-1:0] shd_q;

    always_ff @(posedge clk20) begin
      if (res) begin
        shd_q <= c_def;
        act_q <= c_def;
      end else begin
        if (hit_w) shd_q <= payload_w;
        if (copy_w) act_q <= shd_q;
      end
    end
`else
    always_ff @(posedge clk20) begin
      if (res) begin
        act_q <= c_def;
      end else if (hit_w) begin
        act_q <= payload_w;
      end
    end
`endif

    assign act_flat_w[i*FW +: FW] = act_q;
  end

  always_ff @(posedge clk20) begin
    if (res) begin
      upd_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      upd_q      <= upd_d;
      rd_valid_q <= rd_w;
      err_q      <= err_w;
      if (rd_w) rd_data_q <= {tgt_w, 24'(rd_val_w)};
      if (err_w && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.cfg      = act_flat_w;
  assign bus.pending  = pending_w;
  assign bus.upd      = upd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
endmodule
`default_nettype wire

// File: doc/cfg_regbank.md
CFG_REGBANK -- requirements
Module: cfg_regbank

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NCH, 16, channels per field; power of two, 2..16.
  FW, 8, field width in bits, 1..24.
  NFIELD, 7, number of fields; NFIELD*NCH SHALL be at most 254.
  DEF, {NFIELD{8'd0}} packed NFIELD*FW bits, per-field reset value; field f uses DEF[f*FW +: FW] on every channel.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk20, in, 1, sole clock; all logic on its rising edge.
  res, in, 1, synchronous reset, active-high.
  data, in, 32, command word: [31:24] address, [23:0] payload.
  valid, in, 1, data qualifier; one command per high cycle; always accepted, no backpressure.
  sync, in, 1, one-cycle frame strobe.
  cfg, out, NFIELD*NCH*FW, active registers; register (f,c) at cfg[(f*NCH+c)*FW +: FW].
  pending, out, 1, commit armed.
  upd, out, 1, one-cycle pulse when active registers change.
  rd_valid, out, 1, readback strobe.
  rd_data, out, 32, readback word.
  err, out, 1, one-cycle invalid-address pulse.
  err_cnt, out, 8, saturating invalid-address count.

Function
REQ-003 Address decode uses CB = log2(NCH): field = addr[7:CB], channel = addr[CB-1:0].
REQ-004 Write: valid high with addr < NFIELD*NCH SHALL load data[FW-1:0] into shadow register (field, channel); payload bits above FW are ignored.
REQ-005 Commit: valid high with addr 8'hFF SHALL set pending; payload is ignored.
REQ-006 When sync is high and pending is set, or a commit command is present in the same cycle, all active registers SHALL load from shadow in that cycle; pending clears; upd pulses high in the next cycle.
REQ-007 A shadow write coinciding with the copy in REQ-006 SHALL land in shadow only; active receives the pre-write shadow value.
REQ-008 sync without pending SHALL change nothing; upd stays low.
REQ-009 A repeated commit while pending is already set SHALL leave pending set, with no other effect.
REQ-010 Readback: valid high with addr 8'hFE SHALL, one cycle later, assert rd_valid for one cycle with rd_data = {data[7:0], 24'b0 | active value zero-extended}.
REQ-011 A readback request naming an invalid address SHALL return value 0 and SHALL also trigger err.
REQ-012 Invalid address: a command with addr in NFIELD*NCH..8'hFD SHALL change no register, pulse err one cycle later, and increment err_cnt, which saturates at 255.
REQ-013 valid low SHALL produce no state change other than the sync/commit path.

Reset
REQ-014 res high at a clock edge SHALL set shadow and active to DEF per field, and clear pending, upd, rd_valid, rd_data, err and err_cnt.
REQ-015 res SHALL take priority over valid and sync in the same cycle.
REQ-016 A reset while pending is set SHALL discard the pending commit.

Configuration
REQ-017 Macro CFG_SHADOW_EN defined: double buffering as in REQ-004..REQ-009.
REQ-018 CFG_SHADOW_EN undefined:
  - no shadow storage; writes load active directly;
  - upd pulses one cycle after each accepted write;
  - commit command is a no-op; pending is tied 0; sync is ignored.

Verification
Default parameters, DEF field 0 = 49, CFG_SHADOW_EN defined unless stated.
REQ-019 Reset, then readback of addr 0x03 -> rd_valid after 1 cycle, rd_data = 0x03000031.
REQ-020 Write 0x2500007F, then commit 0xFF000000, no sync -> cfg field 2 ch 5 unchanged and pending = 1; next sync -> value 0x7F, pending = 0, upd pulses once.
REQ-021 Commit with pending already set, sync in the same cycle as write 0x10000055 -> active field 1 ch 0 keeps its old value; a second commit plus sync -> value 0x55.
REQ-022 Write 0x70000001, repeated 300 times -> err pulses each time, no cfg change, err_cnt = 255.
REQ-023 res asserted while pending = 1, then sync -> cfg equals DEF, upd stays low.
REQ-024 CFG_SHADOW_EN undefined: write 0x000000AA -> cfg[7:0] = 0xAA next cycle; upd pulses; sync has no effect.
